// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift sequencer: FSM states, bit-order
// encoding and the serial bit-index mapping used on both send and receive sides.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  // Word bit position for serial slot 'cnt' under the given bit order.
  function automatic int bit_index(input int cnt, input logic order, input int width);
    return (order == MSB_FIRST) ? (width - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// DEPTH-stage serial flop chain with no enable; stands in for the production
// shifter that the sequencer drives (serial in a, serial out e).
module serial_shift_reg #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic a,
  output logic e
);

  logic [DEPTH-1:0] stg;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stg <= '0;
    end else begin
      stg[0] <= a;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign e = stg[DEPTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Serializes a parallel word into a DEPTH-stage shifter and reassembles the
// word from the shifter output, with valid/ready handshakes on both sides.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sh_a,
  input  logic             sh_e,
  output logic             busy
);

  localparam int TOTAL = WIDTH + DEPTH;
  localparam int CW    = $clog2(TOTAL);

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] cap_r;
  logic             order_r;
  logic             last;

  assign last = (state == SHIFT) && (int'(cnt) == TOTAL - 1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Send bits occupy slots 0..WIDTH-1; the matching return bits arrive DEPTH slots later.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt     <= '0;
      data_r  <= '0;
      cap_r   <= '0;
      order_r <= LSB_FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r  <= in_data;
            order_r <= in_msb_first;
            cnt     <= '0;
            cap_r   <= '0;
          end
        end
        SHIFT: begin
          if (int'(cnt) >= DEPTH) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (i == bit_index(int'(cnt) - DEPTH, order_r, WIDTH)) begin
                cap_r[i] <= sh_e;
              end
            end
          end
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Serial output is a mux of registered word and counter; zeros whenever no bit is due.
  always_comb begin
    sh_a = 1'b0;
    if ((state == SHIFT) && (int'(cnt) < WIDTH)) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i == bit_index(int'(cnt), order_r, WIDTH)) begin
          sh_a = data_r[i];
        end
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = cap_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer closed through a serial_shift_reg, with a
// switch that forces the shifter output high to model a faulty shifter.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_msb_first = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             sh_a;
  logic             sh_e;
  logic             busy;
  logic             shr_e;
  logic             fault_sh = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign sh_e = fault_sh ? 1'b1 : shr_e;

  shift_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sh_a(sh_a), .sh_e(sh_e),
    .busy(busy)
  );

  serial_shift_reg #(.DEPTH(DEPTH)) u_shr (
    .clk(clk), .clr(clr), .a(sh_a), .e(shr_e)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             msb;
    logic             fault;
    logic [WIDTH-1:0] exp_out;
    logic [7:0]       exp_sha;  // bit i = sh_a during SHIFT cycle i
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check(name, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  // One full word through the loop; checks sh_a stream, latency and result.
  task automatic run_word(input vec_t v, input int id);
    logic [7:0] seq;
    int         lat;
    wait_ready($sformatf("v%0d_ready", id));
    in_data      = v.data;
    in_msb_first = v.msb;
    fault_sh     = v.fault;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    check($sformatf("v%0d_busy", id), 32'(busy), 32'd1);
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = sh_a;
      if (out_valid) break;
      tick();
      lat++;
    end
    check($sformatf("v%0d_sha", id), 32'(seq), 32'(v.exp_sha));
    check($sformatf("v%0d_latency", id), 32'(lat), 32'd9);
    check($sformatf("v%0d_out_valid", id), 32'(out_valid), 32'd1);
    check($sformatf("v%0d_out_data", id), 32'(out_data), 32'(v.exp_out));
    tick();
    check($sformatf("v%0d_idle", id), 32'(in_ready), 32'd1);
    fault_sh = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] bw[3];
    int idx, oi, last_t, seen;
    logic acc;

    vecs[0] = '{data: 4'b1100, msb: LSB_FIRST, fault: 1'b0, exp_out: 4'b1100, exp_sha: 8'h0C};
    vecs[1] = '{data: 4'b1011, msb: MSB_FIRST, fault: 1'b0, exp_out: 4'b1011, exp_sha: 8'h0D};
    vecs[2] = '{data: 4'b0110, msb: LSB_FIRST, fault: 1'b0, exp_out: 4'b0110, exp_sha: 8'h06};
    vecs[3] = '{data: 4'b0000, msb: LSB_FIRST, fault: 1'b1, exp_out: 4'b1111, exp_sha: 8'h00};
    vecs[4] = '{data: 4'b0001, msb: MSB_FIRST, fault: 1'b0, exp_out: 4'b0001, exp_sha: 8'h08};
    vecs[5] = '{data: 4'b1110, msb: MSB_FIRST, fault: 1'b0, exp_out: 4'b1110, exp_sha: 8'h07};

    // Reset state
    #1 clr = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sh_a", 32'(sh_a), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      run_word(vecs[v], v);
    end

    // Backpressure: hold DONE for 5 cycles with a competing in_valid
    wait_ready("bp_ready");
    in_data = 4'b1001; in_msb_first = LSB_FIRST; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("bp_done");
    in_data = 4'b0011; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_data%0d", i), 32'(out_data), 32'h9);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    check("bp_accept_in_ready", 32'(in_ready), 32'd0);
    wait_out_valid("bp_second_done");
    check("bp_second_data", 32'(out_data), 32'h3);
    tick();

    // Reset in the middle of SHIFT at cnt=3 (sh_a would be data[3]=1)
    wait_ready("mid_ready");
    in_data = 4'b1111; in_msb_first = LSB_FIRST; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_pre_sh_a", 32'(sh_a), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_sh_a", 32'(sh_a), 32'd0);
    check("mid_out_data", 32'(out_data), 32'd0);
    #1 clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_no_output", 32'(seen), 32'd0);
    run_word(vecs[2], 10);

    // Back-to-back with in_valid and out_ready held high
    bw[0] = 4'hA; bw[1] = 4'h5; bw[2] = 4'hF;
    idx = 0; oi = 0; last_t = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (idx < 3) begin
        if (in_ready) in_data = bw[idx];
        in_msb_first = LSB_FIRST;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) idx++;
      if (out_valid && oi < 3) begin
        check($sformatf("b2b_data%0d", oi), 32'(out_data), 32'(bw[oi]));
        if (oi > 0) check($sformatf("b2b_period%0d", oi), 32'(c - last_t), 32'd10);
        last_t = c;
        oi++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(oi), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Controller that drives the team's DEPTH-stage serial bit shifter. It takes a parallel word over a valid/ready handshake and feeds it bit-serially into the shifter's serial input. It collects the bits back from the shifter's serial output and returns the reassembled word over a second valid/ready handshake. It sits between a parallel producer/consumer and the shifter, and sequences every cycle of the shifter, since the shifter itself has no enable.

## Interface
- WIDTH, 4: bits per transferred word.
- DEPTH, 4: shifter stages, i.e. cycles from serial in to serial out; must be ≥1.
- clk  input  1  single clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  word to serialize.
- in_msb_first  input  1  bit order, sampled with in_data.
- out_valid  output  1  reassembled word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  reassembled word.
- sh_a  output  1  serial bit to the shifter input (shifter's A).
- sh_e  input  1  shifter serial output (shifter's E).
- busy  output  1  high in SHIFT or DONE.

## Operation
- **States:**
  - IDLE: in_ready=1.
  - SHIFT: a counter cnt runs 0..WIDTH+DEPTH-1.
  - DONE: out_valid=1.
- **IDLE→SHIFT:** on a rising edge with in_valid=1. The edge captures in_data and in_msb_first, clears cnt to 0 and clears the capture register.
- **Driving sh_a in SHIFT:**
  - For cnt < WIDTH, sh_a = data[cnt] when LSB-first, or data[WIDTH-1-cnt] when MSB-first.
  - For cnt ≥ WIDTH, sh_a = 0 (flush).
- **Capture in SHIFT:** for cnt in DEPTH..DEPTH+WIDTH-1, the edge stores sh_e into bit index k=cnt-DEPTH (LSB-first) or WIDTH-1-k (MSB-first). An ideal shifter therefore returns out_data == in_data.
- **SHIFT→DONE:** on the edge where cnt = WIDTH+DEPTH-1 (that edge also performs the last capture).
- **DONE→IDLE:** on the edge with out_ready=1. out_data holds its value until the next capture begins.
- **sh_a outside SHIFT:** 0 in IDLE and DONE, so the shifter always shifts zeros when no word is in flight.
- **Ignored inputs:**
  - in_valid outside IDLE: ignored, because in_ready=0.
  - out_ready outside DONE: ignored.
- **Reset:** clr=1 at any time, including mid-SHIFT, forces IDLE immediately and asynchronously.
  - Reset values: cnt=0, captured data=0, out_data=0, out_valid=0, in_ready=1 after release, sh_a=0, busy=0.
  - An in-flight word is discarded; no partial output is produced.
- **Width rule:** cnt is $clog2(WIDTH+DEPTH) bits and never wraps beyond WIDTH+DEPTH-1.

## Timing
- in_ready = (state==IDLE), combinational from state only; no combinational path from any input to any output.
- out_valid, out_data, sh_a and busy are derived from registered state/data only; sh_a may be a mux of registered data and cnt.
- Latency, accept edge to out_valid high: WIDTH+DEPTH+1 edges (9 for the 4/4 configuration).
- Minimum period per word with out_ready held high: WIDTH+DEPTH+2 cycles (SHIFT, one DONE cycle, one IDLE cycle).
- The shifter is assumed to sample sh_a on the same clk edge and to be reset by the same clr.

## Structure
- **Package shift_seq_pkg:**
  - state enum {IDLE, SHIFT, DONE}.
  - Bit-order constants LSB_FIRST=0, MSB_FIRST=1.
  - Function computing the serial bit index from (cnt, order, WIDTH).
- **Sub-module serial_shift_reg:**
  - DEPTH-stage flop chain with async active-high clr; ports clk, clr, a, e.
  - Instantiated only in the bench to close the loop sh_a→sh_e.
  - Synthesizable so it can stand in for the production shifter.

## Test plan
- **Basic LSB-first:** WIDTH=4, DEPTH=4, in_data=4'b1100, LSB-first, out_ready=1.
  - sh_a sequence 0,0,1,1,0,0,0,0 over SHIFT.
  - out_valid rises 9 edges after accept with out_data=4'b1100.
- **MSB-first:** in_data=4'b1011, MSB-first → sh_a 1,0,1,1,0,0,0,0 and out_data=4'b1011.
- **Backpressure:** out_ready=0 for 5 cycles in DONE.
  - out_valid and out_data stay stable, in_ready=0, a second in_valid is ignored.
  - Once out_ready=1, the pending word is accepted 2 edges later.
- **Reset mid-SHIFT:** assert clr at cnt=3 for a partial cycle.
  - Outputs go to reset values immediately.
  - No out_valid follows; the next word 4'b0110 returns 4'b0110.
- **Faulty shifter:** sh_e tied 1 with in_data=4'b0000 → out_data=4'b1111, proving out_data comes from capture, not from in_data.
- **Back-to-back:** words 4'hA, 4'h5, 4'hF with in_valid and out_ready held high.
  - Each is returned in order, one word per 10 cycles.
